// File: rtl/bpsk_nco_pkg.sv
// bpsk_nco_pkg: shared definitions for the BPSK carrier generator.
//   - default widths for the sample, phase accumulator and table address
//   - quadrant enum (Q0..Q3) used by the quarter-wave lookup
//   - qw_entry(): generator for the quarter-wave sine table contents.
//     Entry i = round(amp * sin(2*pi*(i+0.5)/2^(aw+2))), amp = 2^(dw-1)-1.
//     It is evaluated at elaboration only and uses integer fixed-point
//     (Q30) Horner-form Taylor series so no real math reaches synthesis.
package bpsk_nco_pkg;

  localparam int DATA_WIDTH_DEF       = 12;
  localparam int PHASE_WIDTH_DEF      = 16;
  localparam int TABLE_ADDR_WIDTH_DEF = 8;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_e;

  // Table entry type for the default configuration (unsigned magnitude).
  typedef logic [DATA_WIDTH_DEF-2:0] qw_entry_t;

  function automatic int qw_entry(input int idx, input int aw, input int dw);
    longint one, x, x2, t, s, amp;
    one = 64'sd1 <<< 30;
    // x = pi*(2*idx+1)/2^(aw+2) in Q30
    x  = (64'sd3373259426 * longint'(2 * idx + 1)) >>> (aw + 2);
    x2 = (x * x) >>> 30;
    // sin x = x(1 - x^2/6(1 - x^2/20(1 - x^2/42(1 - x^2/72(1 - x^2/110(1 - x^2/156))))))
    t  = one - x2 / 156;
    t  = one - ((x2 * t) >>> 30) / 110;
    t  = one - ((x2 * t) >>> 30) / 72;
    t  = one - ((x2 * t) >>> 30) / 42;
    t  = one - ((x2 * t) >>> 30) / 20;
    t  = one - ((x2 * t) >>> 30) / 6;
    s  = (x * t) >>> 30;
    amp = (64'sd1 <<< (dw - 1)) - 64'sd1;
    return int'((amp * s + (one >>> 1)) >>> 30);
  endfunction

endpackage

// File: rtl/bpsk_nco_quarter_wave_lookup.sv
// bpsk_nco_quarter_wave_lookup: 3-stage registered quarter-wave sine lookup.
//   clk, rst_n      : clock, synchronous active-low reset
//   stg_en_i[2:0]   : per-stage load enables (stage valid bits); a stage holds
//                     its contents when its enable is low
//   phase_idx_i     : top TABLE_ADDR_WIDTH+2 phase bits (quadrant + address)
//   sym_i           : BPSK symbol, 1 inverts the carrier
//   sample_o        : signed sample, 3 loads after the phase was presented
// Stage 1 folds the phase into quadrant/address, stage 2 reads the table,
// stage 3 applies the sign.
module bpsk_nco_quarter_wave_lookup
  import bpsk_nco_pkg::*;
#(
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int TABLE_ADDR_WIDTH = TABLE_ADDR_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2:0]                  stg_en_i,
  input  logic [TABLE_ADDR_WIDTH+1:0] phase_idx_i,
  input  logic                        sym_i,
  output logic [DATA_WIDTH-1:0]       sample_o
);

  localparam int ENTRIES = 2 ** TABLE_ADDR_WIDTH;

  // Quarter-wave ROM, contents fixed at elaboration.
  logic [DATA_WIDTH-2:0] rom [ENTRIES];
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_rom
    localparam int E = qw_entry(gi, TABLE_ADDR_WIDTH, DATA_WIDTH);
    assign rom[gi] = (DATA_WIDTH-1)'(E);
  end

  quadrant_e                   quad_c, quad_s1_q;
  logic [TABLE_ADDR_WIDTH-1:0] addr_c, addr_s1_q;
  logic                        sym_s1_q;
  logic [DATA_WIDTH-2:0]       mag_s2_q;
  logic                        neg_s2_q;
  logic [DATA_WIDTH-1:0]       sample_q;

  assign quad_c = quadrant_e'(phase_idx_i[TABLE_ADDR_WIDTH+1:TABLE_ADDR_WIDTH]);
  // Odd quadrants run the table backwards; the half-step sample offset
  // makes ~addr land exactly on the mirrored point.
  assign addr_c = (quad_c == Q1 || quad_c == Q3) ? ~phase_idx_i[TABLE_ADDR_WIDTH-1:0]
                                                 :  phase_idx_i[TABLE_ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quad_s1_q <= Q0;
      addr_s1_q <= '0;
      sym_s1_q  <= 1'b0;
      mag_s2_q  <= '0;
      neg_s2_q  <= 1'b0;
      sample_q  <= '0;
    end else begin
      if (stg_en_i[0]) begin
        quad_s1_q <= quad_c;
        addr_s1_q <= addr_c;
        sym_s1_q  <= sym_i;
      end
      if (stg_en_i[1]) begin
        mag_s2_q <= rom[addr_s1_q];
        // second half-cycle of the wave is negative; symbol 1 flips it again
        neg_s2_q <= (quad_s1_q == Q2 || quad_s1_q == Q3) ^ sym_s1_q;
      end
      if (stg_en_i[2]) begin
        // magnitude < 2^(DATA_WIDTH-1) so negation never overflows
        sample_q <= neg_s2_q ? -{1'b0, mag_s2_q} : {1'b0, mag_s2_q};
      end
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/bpsk_nco.sv
// bpsk_nco: BPSK carrier generator (phase accumulator + quarter-wave lookup).
//   clk, rst_n    : clock, synchronous active-low reset
//   enable        : advance phase/symbol counter and issue one sample
//   ftw_load, ftw : load the tuning word (used from the next enabled cycle)
//   symbol_valid  : symbol_data offered; consumed only when symbol_ready
//   symbol_data   : 0 = carrier as-is, 1 = inverted
//   symbol_ready  : enabled cycle on the last sample of a symbol
//   sample_out    : signed sample, updated when sample_valid
//   sample_valid  : enable delayed by 3 cycles
//   underrun      : sticky, a symbol boundary passed without a symbol
// Optional: define BPSK_NCO_QUAD_OUT_EN to add sample_q_out, the quadrature
// (cosine) sample sharing sample_valid.
module bpsk_nco
  import bpsk_nco_pkg::*;
#(
  parameter int DATA_WIDTH         = DATA_WIDTH_DEF,
  parameter int PHASE_WIDTH        = PHASE_WIDTH_DEF,
  parameter int TABLE_ADDR_WIDTH   = TABLE_ADDR_WIDTH_DEF,
  parameter int SAMPLES_PER_SYMBOL = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   ftw_load,
  input  logic [PHASE_WIDTH-1:0] ftw,
  input  logic                   symbol_valid,
  input  logic                   symbol_data,
  output logic                   symbol_ready,
  output logic [DATA_WIDTH-1:0]  sample_out,
  output logic                   sample_valid,
  output logic                   underrun
`ifdef BPSK_NCO_QUAD_OUT_EN
  ,
  output logic [DATA_WIDTH-1:0]  sample_q_out
`endif
);

  localparam int CNT_W  = $clog2(SAMPLES_PER_SYMBOL);
  localparam int IDX_W  = TABLE_ADDR_WIDTH + 2;
  localparam int STAGES = 3;

  logic [PHASE_WIDTH-1:0] acc_q, acc_d, ftw_q, ftw_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sym_q, sym_d;
  logic                   under_q, under_d;
  logic [STAGES:1]        vld_pipe_q;
  logic                   last_c;
  logic [IDX_W-1:0]       idx_c;

  assign last_c       = (cnt_q == CNT_W'(SAMPLES_PER_SYMBOL - 1));
  assign symbol_ready = rst_n & enable & last_c;
  assign idx_c        = acc_q[PHASE_WIDTH-1 -: IDX_W];

  always_comb begin
    acc_d   = acc_q;
    ftw_d   = ftw_load ? ftw : ftw_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    under_d = under_q;
    if (enable) begin
      // old ftw_q is used even when ftw_load is high this cycle
      acc_d = acc_q + ftw_q;
      if (last_c) begin
        cnt_d = '0;
        if (symbol_valid) sym_d   = symbol_data;
        else              under_d = 1'b1;  // keep previous symbol
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= '0;
      ftw_q      <= '0;
      cnt_q      <= '0;
      sym_q      <= 1'b0;
      under_q    <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      acc_q      <= acc_d;
      ftw_q      <= ftw_d;
      cnt_q      <= cnt_d;
      sym_q      <= sym_d;
      under_q    <= under_d;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], enable};
    end
  end

  assign sample_valid = vld_pipe_q[STAGES];
  assign underrun     = under_q;

  bpsk_nco_quarter_wave_lookup #(
    .DATA_WIDTH       (DATA_WIDTH),
    .TABLE_ADDR_WIDTH (TABLE_ADDR_WIDTH)
  ) u_lookup_i (
    .clk         (clk),
    .rst_n       (rst_n),
    .stg_en_i    ({vld_pipe_q[2:1], enable}),
    .phase_idx_i (idx_c),
    .sym_i       (sym_q),
    .sample_o    (sample_out)
  );

`ifdef BPSK_NCO_QUAD_OUT_EN
  logic [IDX_W-1:0] idx_q_c;
  // quarter turn ahead = quadrant + 1
  assign idx_q_c = idx_c + {2'b01, {TABLE_ADDR_WIDTH{1'b0}}};

  bpsk_nco_quarter_wave_lookup #(
    .DATA_WIDTH       (DATA_WIDTH),
    .TABLE_ADDR_WIDTH (TABLE_ADDR_WIDTH)
  ) u_lookup_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .stg_en_i    ({vld_pipe_q[2:1], enable}),
    .phase_idx_i (idx_q_c),
    .sym_i       (sym_q),
    .sample_o    (sample_q_out)
  );
`endif

endmodule

// File: doc/bpsk_nco.md
Name: bpsk_nco

Overview:
- Parametrised BPSK carrier generator: phase accumulator, quarter-wave sine table lookup and per-symbol phase inversion.
- Consumes one data symbol per SAMPLES_PER_SYMBOL samples through a valid/ready handshake and emits one signed sample per enabled cycle.
- Sits between the symbol source and the DAC/output formatter.
- Generalises the full/half-table sine lookup to quarter-wave storage, runtime frequency and a registered 3-stage pipeline.

Parameters:
- DATA_WIDTH, 12, signed output sample width.
- PHASE_WIDTH, 16, phase accumulator and tuning word width.
- TABLE_ADDR_WIDTH, 8, quarter-wave table address bits (2^TABLE_ADDR_WIDTH entries); must be ≤ PHASE_WIDTH-2.
- SAMPLES_PER_SYMBOL, 4, samples per BPSK symbol; ≥2.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset; synchronous to clk, active low.
- enable, input, 1, advance accumulator/symbol counter and issue a sample this cycle.
- ftw_load, input, 1, load ftw into the tuning register.
- ftw, input, PHASE_WIDTH, frequency tuning word (phase increment per sample).
- symbol_valid, input, 1, symbol_data is valid.
- symbol_data, input, 1, 0 = carrier as-is, 1 = carrier inverted.
- symbol_ready, output, 1, block accepts a symbol this cycle.
- sample_out, output, DATA_WIDTH, signed two's-complement sample.
- sample_valid, output, 1, sample_out is new this cycle.
- underrun, output, 1, sticky: a symbol boundary passed with no symbol available.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Clears the accumulator, tuning register, symbol counter, current symbol, all pipeline registers, underrun, symbol_ready, sample_valid and sample_out to 0.
  - Takes priority over every other input.
  - A reset mid-symbol discards the in-flight symbol and pipeline contents.
- Tuning:
  - ftw_load takes effect on the following edge.
  - The new increment applies from the next enabled cycle.
  - Simultaneous ftw_load and enable: the current step uses the old ftw.
- Accumulator:
  - On enable, phase <= phase + ftw, modulo 2^PHASE_WIDTH (natural wrap, no saturation).
  - Without enable, phase holds.
- Symbol counter:
  - Counts 0..SAMPLES_PER_SYMBOL-1 on enable, then wraps.
  - symbol_ready = enable && (count == SAMPLES_PER_SYMBOL-1), combinational from registered count.
  - Transfer occurs when symbol_ready && symbol_valid; the new symbol governs samples from the next enabled cycle.
  - At a boundary without symbol_valid, the previous symbol is repeated and underrun sets; it clears only on reset.
  - symbol_valid outside a boundary is ignored (not consumed).
- Lookup: phase index p = the top TABLE_ADDR_WIDTH+2 bits of the accumulator.
  - Quadrant q = p[MSB:MSB-1]; addr = remaining bits.
  - q[0]=1 uses the mirrored address ~addr.
  - Negate when q[1] XOR current_symbol.
- Table contents: entry i = round((2^(DATA_WIDTH-1)-1) * sin(2π(i+0.5)/2^(TABLE_ADDR_WIDTH+2))).
  - Stored unsigned in DATA_WIDTH-1 bits and generated by the build script.
  - The half-step offset makes the mirror exact.
  - Negation never overflows; the most negative code is never produced.
- Pipeline:
  - Stage 1 registers quadrant, address and symbol.
  - Stage 2 registers the table read.
  - Stage 3 registers the sign-applied sample.
  - Latency is 3 cycles from the enabled cycle that used a phase to sample_valid.
  - sample_valid is enable delayed by 3.
  - sample_out holds its value when sample_valid is low.
- enable low: accumulator, counter and symbol freeze. In-flight samples still drain and bubbles propagate. No handshake completes.

Optional Feature:
- Macro BPSK_NCO_QUAD_OUT_EN.
- When defined: adds output port sample_q_out (DATA_WIDTH), the quadrature (cosine) sample.
  - Uses phase + quarter turn, i.e. quadrant+1, with the same symbol sign and the same 3-cycle latency.
  - Shares the sample_valid qualifier.
  - Uses a second table read port.
- When undefined: the port and its logic are absent; everything else is identical.

Decomposition:
- Shared package holds:
  - the generated quarter-wave table constant and its type;
  - DATA_WIDTH / PHASE_WIDTH / TABLE_ADDR_WIDTH defaults;
  - the quadrant typedef (2-bit enum Q0..Q3).
- Sub-module quarter_wave_lookup contains stages 1–3 only: phase index + symbol in, signed sample out, 3-cycle latency.
  - Instantiated once, or twice under BPSK_NCO_QUAD_OUT_EN.
- The top level holds the accumulator, symbol counter, handshake and underrun.

Test Plan (defaults):
- Reset: rst_n low 5 cycles with enable=1, symbol_valid=1 -> sample_valid=0, sample_out=0, symbol_ready=0, underrun=0 throughout.
- ftw=0x4000, symbol stream all 0, enable constant -> after 3-cycle latency sample_out repeats 6, 2047, -6, -2047.
- Same ftw, symbols 0 then 1 presented on successive boundaries -> second 4-sample group is -6, -2047, 6, 2047; transfers occur only when symbol_ready=1.
- Hold symbol_valid=0 at a boundary -> underrun rises the next cycle and stays 1, previous symbol's polarity repeats; only rst_n clears it.
- enable toggled 1,0,0,1 mid-symbol with ftw=0x1000 -> sample_valid mirrors enable delayed 3, phase skips no steps, symbol boundary delayed by 2 cycles.
- ftw_load with ftw=0x8000 coincident with enable -> that sample uses the old step, next steps use 0x8000; output then alternates 6, -6 (symbol 0).
